// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle for instr_fetch_queue: redirect input, instruction
// memory request/response channel and the IF/ID valid/ready output.
interface instr_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_add_result;
  logic        queue_full;
  logic        resp_error;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_resp_valid, imem_resp_data, out_ready,
    output imem_req, imem_addr, out_valid, out_instruction, out_pc, out_pc_add_result,
           queue_full, resp_error
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_resp_valid, imem_resp_data, out_ready,
    input  imem_req, imem_addr, out_valid, out_instruction, out_pc, out_pc_add_result,
           queue_full, resp_error
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to a variable-latency
// memory, keeps returned words in an in-order circular queue and hands them to
// IF/ID. A redirect flushes the queue and discards responses still in flight.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_queue_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [PW-1:0] head_ptr_reg;
  // issue/fill pointers carry a wrap bit so their difference counts 0..DEPTH
  logic [CW-1:0] issue_ptr_reg;
  logic [CW-1:0] fill_ptr_reg;
  logic [CW-1:0] used_cnt_reg;
  logic [CW-1:0] discard_cnt_reg;
  logic          resp_error_reg;

  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_pc4  [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [DEPTH-1:0] slot_issue_we;
  logic [DEPTH-1:0] slot_fill_we;

  logic [PW-1:0] issue_idx;
  logic [PW-1:0] fill_idx;
  logic [CW-1:0] pending_cnt;
  logic [CW:0]   busy_sum;
  logic [CW:0]   discard_sum;
  logic          issue_fire;
  logic          pop_fire;
  logic          out_valid_int;
  logic          resp_to_discard;
  logic          resp_to_slot;
  logic          unused_redirect_bits;

  assign issue_idx   = issue_ptr_reg[PW-1:0];
  assign fill_idx    = fill_ptr_reg[PW-1:0];
  assign pending_cnt = issue_ptr_reg - fill_ptr_reg;
  assign busy_sum    = {1'b0, used_cnt_reg} + {1'b0, discard_cnt_reg};
  // squashed responses after a redirect: older discards plus every slot still waiting
  assign discard_sum = {1'b0, discard_cnt_reg} + {1'b0, pending_cnt};

  // rst_n gating keeps the request low for the whole time reset is held
  assign bus.imem_req  = rst_n & (busy_sum < DEPTH_W) & ~bus.redirect;
  assign bus.imem_addr = fetch_pc_reg;
  assign issue_fire    = bus.imem_req & bus.imem_ack;

  assign resp_to_discard = bus.imem_resp_valid & (discard_cnt_reg != '0);
  assign resp_to_slot    = bus.imem_resp_valid & (discard_cnt_reg == '0) &
                           (pending_cnt != '0) & ~bus.redirect;

  assign out_valid_int         = slot_filled[head_ptr_reg] & (used_cnt_reg != '0) & ~bus.redirect;
  assign pop_fire              = out_valid_int & bus.out_ready;
  assign bus.out_valid         = out_valid_int;
  assign bus.out_instruction   = slot_data[head_ptr_reg];
  assign bus.out_pc            = slot_pc[head_ptr_reg];
  assign bus.out_pc_add_result = slot_pc4[head_ptr_reg];
  assign bus.queue_full        = (used_cnt_reg == DEPTH_C);
  assign bus.resp_error        = resp_error_reg;

  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [31:0] pc_reg;
      logic [31:0] pc4_reg;
      logic [31:0] data_reg;
      logic        filled_reg;

      assign slot_issue_we[gi] = issue_fire & (issue_idx == PW'(gi));
      assign slot_fill_we[gi]  = resp_to_slot & (fill_idx == PW'(gi));
      assign slot_pc[gi]       = pc_reg;
      assign slot_pc4[gi]      = pc4_reg;
      assign slot_data[gi]     = data_reg;
      assign slot_filled[gi]   = filled_reg;

      // Slot capture: address on reservation, word on fill; redirect drops the filled mark.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_reg     <= '0;
          pc4_reg    <= '0;
          data_reg   <= '0;
          filled_reg <= 1'b0;
        end else begin
          if (slot_issue_we[gi]) begin
            pc_reg  <= fetch_pc_reg;
            pc4_reg <= fetch_pc_reg + 32'd4;
          end
          if (slot_fill_we[gi]) begin
            data_reg <= bus.imem_resp_data;
          end
          if (bus.redirect || slot_issue_we[gi]) begin
            filled_reg <= 1'b0;
          end else if (slot_fill_we[gi]) begin
            filled_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Fetch PC, queue pointers, occupancy/discard counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      head_ptr_reg    <= '0;
      issue_ptr_reg   <= '0;
      fill_ptr_reg    <= '0;
      used_cnt_reg    <= '0;
      discard_cnt_reg <= '0;
      resp_error_reg  <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc_reg  <= {bus.redirect_pc[31:2], 2'b00};
      head_ptr_reg  <= '0;
      issue_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      used_cnt_reg  <= '0;
      if (!bus.imem_resp_valid) begin
        discard_cnt_reg <= discard_sum[CW-1:0];
      end else if (discard_sum != '0) begin
        // the response arriving now is one of the squashed ones
        discard_cnt_reg <= discard_sum[CW-1:0] - CW'(1);
      end else begin
        resp_error_reg <= 1'b1;
      end
    end else begin
      if (issue_fire) begin
        issue_ptr_reg <= issue_ptr_reg + CW'(1);
        fetch_pc_reg  <= fetch_pc_reg + 32'd4;
      end
      if (resp_to_discard) begin
        discard_cnt_reg <= discard_cnt_reg - CW'(1);
      end
      if (resp_to_slot) begin
        fill_ptr_reg <= fill_ptr_reg + CW'(1);
      end
      if (bus.imem_resp_valid && !resp_to_discard && !resp_to_slot) begin
        resp_error_reg <= 1'b1;
      end
      if (pop_fire) begin
        head_ptr_reg <= head_ptr_reg + PW'(1);
      end
      if (issue_fire && !pop_fire) begin
        used_cnt_reg <= used_cnt_reg + CW'(1);
      end else if (!issue_fire && pop_fire) begin
        used_cnt_reg <= used_cnt_reg - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a behavioural memory answers accepted
// requests after a programmable latency; every accepted address is queued as an
// expected output and compared when IF/ID pops it.
module tb_instr_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  logic clk = 1'b0;
  logic rst_n;
  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  mem_t        mem_q[$];
  logic [31:0] sb[$];
  logic [31:0] acc_log[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops = 0;
  int          first_valid_cyc = -1;
  bit          spur = 1'b0;
  bit          chk_next_addr = 1'b0;
  bit          last_pop_valid = 1'b0;
  logic [31:0] next_addr_exp = '0;
  logic [31:0] last_pop_pc = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample outputs, update models, advance.
  task automatic step();
    bit          acc;
    bit          pop;
    logic [31:0] e_pc;
    if (spur) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hBAD0_BAD0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = instr_of(mem_q[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    #1;
    if (chk_next_addr) begin
      check("next_req", 32'(bus.imem_req), 32'd1);
      check("next_addr", bus.imem_addr, next_addr_exp);
      chk_next_addr = 1'b0;
    end
    if (bus.redirect) check("redirect_no_valid", 32'(bus.out_valid), 32'd0);
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    acc = bus.imem_req & bus.imem_ack;
    pop = bus.out_valid & bus.out_ready;
    if (pop) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 32'(bus.out_valid), 32'd0);
      end else begin
        e_pc = sb.pop_front();
        check("out_pc", bus.out_pc, e_pc);
        check("out_instr", bus.out_instruction, instr_of(e_pc));
        check("out_pc4", bus.out_pc_add_result, e_pc + 32'd4);
        $display("pop cyc=%0d pc=%h instr=%h", cyc, bus.out_pc, bus.out_instruction);
      end
      n_pops++;
    end
    last_pop_valid = pop;
    last_pop_pc    = bus.out_pc;
    if (bus.redirect) begin
      sb.delete();
      chk_next_addr = 1'b1;
      next_addr_exp = {bus.redirect_pc[31:2], 2'b00};
    end
    if (acc) begin
      mem_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
      sb.push_back(bus.imem_addr);
      acc_log.push_back(bus.imem_addr);
    end
    if (bus.imem_resp_valid && !spur) void'(mem_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_pop_pc(input string tag, input logic [31:0] pc, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (last_pop_valid && last_pop_pc == pc) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int p0;
    bit found;
    rst_n               = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_ack        = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_full", 32'(bus.queue_full), 32'd0);
    check("rst_err", 32'(bus.resp_error), 32'd0);
    check("rst_instr", bus.out_instruction, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_pc4", bus.out_pc_add_result, 32'd0);

    // backpressure from reset: queue fills, nothing pops
    rst_n         = 1'b1;
    cyc           = 0;
    chk_next_addr = 1'b1;
    next_addr_exp = RESET_PC;
    lat           = 1;
    repeat (10) step();
    check("bp_accepts", acc_log.size(), 32'd4);
    check("first_valid_cyc", first_valid_cyc, 32'd2);
    check("bp_full", 32'(bus.queue_full), 32'd1);
    check("bp_req", 32'(bus.imem_req), 32'd0);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    check("bp_instr", bus.out_instruction, instr_of(RESET_PC));
    check("bp_pc", bus.out_pc, RESET_PC);

    // release backpressure: drain in order, fetch resumes at 0x110
    acc_log.delete();
    bus.out_ready = 1'b1;
    repeat (6) step();
    if (acc_log.size() > 0) check("resume_addr", acc_log[0], 32'h0000_0110);
    else check("resume_count", acc_log.size(), 32'd1);
    p0 = n_pops;
    repeat (8) step();
    check("stream_rate", n_pops - p0, 32'd8);

    // redirect with three responses in flight (latency 3)
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_q.size() == 3) found = 1'b1;
      else step();
    end
    check("three_outstanding", 32'(found), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_2002;
    step();
    bus.redirect = 1'b0;
    wait_pop_pc("redir_first_pop", 32'h0000_2000, 30);

    // redirect coincident with a response and OutReady=1 (latency 1)
    lat = 1;
    repeat (6) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) found = 1'b1;
      else step();
    end
    check("resp_due_found", 32'(found), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_3001;
    step();
    bus.redirect = 1'b0;
    wait_pop_pc("coinc_first_pop", 32'h0000_3000, 20);

    // spurious response while idle and empty
    bus.imem_ack = 1'b0;
    repeat (8) step();
    check("idle_empty", sb.size(), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("err_before", 32'(bus.resp_error), 32'd0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    check("spur_err", 32'(bus.resp_error), 32'd1);
    check("spur_valid", 32'(bus.out_valid), 32'd0);
    check("spur_full", 32'(bus.queue_full), 32'd0);
    repeat (3) step();
    check("spur_err_sticky", 32'(bus.resp_error), 32'd1);
    bus.imem_ack = 1'b1;
    p0 = n_pops;
    repeat (6) step();
    check("after_spur_pops", 32'(n_pops - p0 >= 3), 32'd1);

    // asynchronous reset between edges with a full queue
    bus.out_ready = 1'b0;
    repeat (8) step();
    check("pre_rst_full", 32'(bus.queue_full), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_full", 32'(bus.queue_full), 32'd0);
    check("arst_pc", bus.out_pc, 32'd0);
    check("arst_err", 32'(bus.resp_error), 32'd0);
    mem_q.delete();
    sb.delete();
    bus.imem_resp_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    chk_next_addr = 1'b1;
    next_addr_exp = RESET_PC;
    wait_pop_pc("post_rst_first_pop", RESET_PC, 10);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
